fp_special_pipe: RTL and testbench

FP_SPECIAL_PIPE -- requirements
Module: fp_special_pipe

---
 rtl/fp_pkg.sv | 27 ++
 rtl/fp_special_pipe_classify.sv | 27 ++
 rtl/fp_special_pipe.sv | 155 +++++++++++++++
 tb/tb_fp_special_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand class encodings, class-field
// localparams and the canonical quiet-NaN builder.
package fp_pkg;

  localparam int CLS_W = 3;
  localparam int MAX_W = 64;

  // Bit 0 of a class code marks a finite, nonzero operand.
  localparam int CLS_FINITE_NZ_BIT = 0;

  typedef enum logic [CLS_W-1:0] {
    CLS_ZERO = 3'b000,
    CLS_SUB  = 3'b001,
    CLS_NORM = 3'b011,
    CLS_INF  = 3'b100,
    CLS_NAN  = 3'b110
  } fp_cls_e;

  // Sign 0, exponent all ones, only the mantissa MSB set.
  function automatic logic [MAX_W-1:0] canonical_nan(input int exp_w, input int man_w);
    logic [MAX_W-1:0] r;
    r = ((64'(1) << exp_w) - 64'(1)) << man_w;
    r = r | (64'(1) << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_special_pipe_classify.sv
// fp_classify: combinational operand classifier (ZERO/SUB/NORM/INF/NAN).
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] i_val,
  output fp_cls_e              o_cls
);

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;

  assign w_exp = i_val[MAN_W +: EXP_W];
  assign w_man = i_val[MAN_W-1:0];

  always_comb begin
    o_cls = CLS_NORM;
    if (w_exp == '0) begin
      o_cls = (w_man == '0) ? CLS_ZERO : CLS_SUB;
    end else if (&w_exp) begin
      o_cls = (w_man == '0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/fp_special_pipe.sv
// Two-stage special-case resolver for FP addition; NaN payload propagation
// is enabled by defining FP_SPECIAL_NAN_PROPAGATE_EN.
module fp_special_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_en,
  output logic [EXP_W+MAN_W:0]     out_s,
  output logic [2:0]               out_cls_a,
  output logic [2:0]               out_cls_b,
  output logic                     flag_invalid,
  input  logic                     flag_clr,
  output logic [CNT_W-1:0]         spec_cnt
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [MAX_W-1:0] C_QNAN_FULL = canonical_nan(EXP_W, MAN_W);
  localparam logic [W-1:0]     C_QNAN      = C_QNAN_FULL[W-1:0];

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a stalled stage holds its contents unchanged.
  fp_cls_e        w_cls_a, w_cls_b;
  logic           w_s1_free, w_s2_free, w_xfer;
  logic [W-1:0]   w_res;
  logic           w_en, w_inv;
  logic           w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

  logic           r_s1_valid;
  logic [W-1:0]   r_s1_a, r_s1_b;
  fp_cls_e        r_s1_cls_a, r_s1_cls_b;

  logic           r_s2_valid;
  logic           r_s2_inv;
  logic           r_out_en;
  logic [W-1:0]   r_out_s;
  fp_cls_e        r_out_cls_a, r_out_cls_b;
  logic           r_flag;
  logic [CNT_W-1:0] r_cnt;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.i_val(in_a), .o_cls(w_cls_a));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.i_val(in_b), .o_cls(w_cls_b));

  assign w_s2_free = !r_s2_valid || out_ready;
  assign w_s1_free = !r_s1_valid || w_s2_free;
  assign w_xfer    = r_s2_valid && out_ready;

  assign w_a_nan  = (r_s1_cls_a == CLS_NAN);
  assign w_b_nan  = (r_s1_cls_b == CLS_NAN);
  assign w_a_inf  = (r_s1_cls_a == CLS_INF);
  assign w_b_inf  = (r_s1_cls_b == CLS_INF);
  assign w_a_zero = (r_s1_cls_a == CLS_ZERO);
  assign w_b_zero = (r_s1_cls_b == CLS_ZERO);

  always_comb begin
    w_res = '0;
    w_en  = 1'b0;
    w_inv = 1'b0;
    if (w_a_nan || w_b_nan) begin
      w_inv = 1'b1;
`ifdef FP_SPECIAL_NAN_PROPAGATE_EN
      w_res = w_a_nan ? r_s1_a : r_s1_b;
      w_res[MAN_W-1] = 1'b1;
`else
      w_res = C_QNAN;
`endif
    end else if (w_a_inf && w_b_inf) begin
      if (r_s1_a[W-1] != r_s1_b[W-1]) begin
        w_res = C_QNAN;
        w_inv = 1'b1;
      end else begin
        w_res = r_s1_a;
      end
    end else if (w_a_inf) begin
      w_res = r_s1_a;
    end else if (w_b_inf) begin
      w_res = r_s1_b;
    end else if (w_a_zero && w_b_zero) begin
      w_res = {r_s1_a[W-1] & r_s1_b[W-1], {(W-1){1'b0}}};
    end else if (w_a_zero) begin
      w_res = r_s1_b;
    end else if (w_b_zero) begin
      w_res = r_s1_a;
    end else begin
      w_en = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_cls_a  <= CLS_ZERO;
      r_s1_cls_b  <= CLS_ZERO;
      r_s2_valid  <= 1'b0;
      r_s2_inv    <= 1'b0;
      r_out_en    <= 1'b0;
      r_out_s     <= '0;
      r_out_cls_a <= CLS_ZERO;
      r_out_cls_b <= CLS_ZERO;
      r_flag      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_s1_free) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_a     <= in_a;
          r_s1_b     <= in_b;
          r_s1_cls_a <= w_cls_a;
          r_s1_cls_b <= w_cls_b;
        end
      end
      if (w_s2_free) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_inv    <= w_inv;
          r_out_en    <= w_en;
          r_out_s     <= w_res;
          r_out_cls_a <= r_s1_cls_a;
          r_out_cls_b <= r_s1_cls_b;
        end
      end
      // A new invalid event outranks a simultaneous clear.
      if (w_xfer && r_s2_inv) begin
        r_flag <= 1'b1;
      end else if (flag_clr) begin
        r_flag <= 1'b0;
      end
      if (w_xfer && !r_out_en && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready     = w_s1_free;
  assign out_valid    = r_s2_valid;
  assign out_en       = r_out_en;
  assign out_s        = r_out_s;
  assign out_cls_a    = r_out_cls_a;
  assign out_cls_b    = r_out_cls_b;
  assign flag_invalid = r_flag;
  assign spec_cnt     = r_cnt;

endmodule

// File: tb/tb_fp_special_pipe.sv
// Scoreboard bench for fp_special_pipe (binary32 layout, 2-bit event counter).
module tb_fp_special_pipe;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int NV      = 13;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_a, in_b;
  logic        in_valid, in_ready;
  logic        out_valid, out_ready;
  logic        out_en;
  logic [31:0] out_s;
  logic [2:0]  out_cls_a, out_cls_b;
  logic        flag_invalid, flag_clr;
  logic [CNT_W-1:0] spec_cnt;

  fp_special_pipe #(.EXP_W(8), .MAN_W(23), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_en(out_en), .out_s(out_s), .out_cls_a(out_cls_a), .out_cls_b(out_cls_b),
    .flag_invalid(flag_invalid), .flag_clr(flag_clr), .spec_cnt(spec_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  logic [31:0] v_a [NV];
  logic [31:0] v_b [NV];
  logic [31:0] v_s [NV];
  logic        v_en[NV];
  logic        v_inv[NV];
  logic [2:0]  v_ca[NV];
  logic [2:0]  v_cb[NV];

  task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] s, input logic en,
                         input logic [2:0] ca, input logic [2:0] cb, input logic inv);
    v_a[i] = a; v_b[i] = b; v_s[i] = s; v_en[i] = en;
    v_ca[i] = ca; v_cb[i] = cb; v_inv[i] = inv;
  endtask

  // ---------------- scoreboard state ----------------
  logic [39:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  int          exp_cnt  = 0;
  logic        exp_flag = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_vec(input int i);
    bit got;
    in_a     = v_a[i];
    in_b     = v_b[i];
    in_valid = 1'b1;
    got      = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({v_inv[i], v_en[i], v_ca[i], v_cb[i], v_s[i]});
        n_acc++;
        got = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got no in_ready expected accept of vector %0d", i);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 100; c++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic async_reset_checks();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_en", out_en, 0);
    check("rst_out_s", out_s, 0);
    check("rst_cls_a", out_cls_a, 0);
    check("rst_cls_b", out_cls_b, 0);
    check("rst_flag", flag_invalid, 0);
    check("rst_spec_cnt", spec_cnt, 0);
  endtask

  // ---------------- monitor ----------------
  logic        prev_stall = 1'b0;
  logic [31:0] prev_s;
  logic [7:0]  prev_meta;

  always @(negedge clk) begin
    logic [39:0] e;
    logic        popped_inv;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      check("spec_cnt", spec_cnt, exp_cnt);
      check("flag_invalid", flag_invalid, exp_flag);
      if (prev_stall) begin
        check("hold_s", out_s, prev_s);
        check("hold_meta", {out_valid, out_en, out_cls_a, out_cls_b}, prev_meta);
      end
      popped_inv = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_out: got 0x%0h expected no output", out_s);
        end else begin
          e = exp_q.pop_front();
          check("out_s", out_s, e[31:0]);
          check("out_en", out_en, e[38]);
          check("out_cls_a", out_cls_a, e[37:35]);
          check("out_cls_b", out_cls_b, e[34:32]);
          popped_inv = e[39];
          if (!e[38] && exp_cnt != CNT_MAX) exp_cnt++;
        end
      end
      exp_flag   = popped_inv || (exp_flag && !flag_clr);
      prev_stall = out_valid && !out_ready;
      prev_s     = out_s;
      prev_meta  = {out_valid, out_en, out_cls_a, out_cls_b};
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    set_vec(0,  32'h3F800000, 32'h80000000, 32'h3F800000, 1'b0, 3'b011, 3'b000, 1'b0);
    set_vec(1,  32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 3'b100, 3'b100, 1'b1);
`ifdef FP_SPECIAL_NAN_PROPAGATE_EN
    set_vec(2,  32'h7FA00001, 32'h3F800000, 32'h7FE00001, 1'b0, 3'b110, 3'b011, 1'b1);
`else
    set_vec(2,  32'h7FA00001, 32'h3F800000, 32'h7FC00000, 1'b0, 3'b110, 3'b011, 1'b1);
`endif
    set_vec(3,  32'h00000001, 32'h40000000, 32'h00000000, 1'b1, 3'b001, 3'b011, 1'b0);
    set_vec(4,  32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 3'b000, 3'b000, 1'b0);
    set_vec(5,  32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 3'b000, 3'b000, 1'b0);
    set_vec(6,  32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 3'b100, 3'b011, 1'b0);
    set_vec(7,  32'h12345678, 32'hFF800000, 32'hFF800000, 1'b0, 3'b011, 3'b100, 1'b0);
    set_vec(8,  32'hFF800000, 32'hFF800000, 32'hFF800000, 1'b0, 3'b100, 3'b100, 1'b0);
    set_vec(9,  32'h3F800000, 32'h7FC00000, 32'h7FC00000, 1'b0, 3'b011, 3'b110, 1'b1);
    set_vec(10, 32'h00000000, 32'h007FFFFF, 32'h007FFFFF, 1'b0, 3'b000, 3'b001, 1'b0);
    set_vec(11, 32'h3F800000, 32'h40000000, 32'h00000000, 1'b1, 3'b011, 3'b011, 1'b0);
`ifdef FP_SPECIAL_NAN_PROPAGATE_EN
    set_vec(12, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 3'b110, 3'b000, 1'b1);
`else
    set_vec(12, 32'hFFFFFFFF, 32'h00000000, 32'h7FC00000, 1'b0, 3'b110, 3'b000, 1'b1);
`endif

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b1; flag_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 async_reset_checks();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", in_ready, 1);

    // Latency: accepted on edge k, visible after edge k+1.
    push_vec(0);
    idle();
    @(negedge clk) check("lat_one_cycle", out_valid, 0);
    @(negedge clk) check("lat_two_cycles", out_valid, 1);
    @(posedge clk); #1;
    drain();

    push_vec(3);
    idle();
    drain();
    check("cnt_after_main_path", spec_cnt, 1);

    push_vec(1);
    idle();
    drain();
    check("flag_set_after_inf", flag_invalid, 1);
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    check("flag_cleared", flag_invalid, 0);
    check("cnt_unaffected_by_clr", spec_cnt, 2);

    for (int i = 2; i < NV; i++) push_vec(i);
    idle();
    drain();
    check("cnt_saturated", spec_cnt, CNT_MAX);

    // Backpressure: out_ready low for three edges while four inputs queue up.
    n_acc = 0;
    fork
      begin
        for (int i = 4; i < 8; i++) push_vec(i);
        idle();
      end
      begin
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_accepts_before_stall", n_acc, 2);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_total_accepts", n_acc, 4);

    // Reset with two operations in flight.
    push_vec(0);
    push_vec(1);
    idle();
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt  = 0;
    exp_flag = 1'b0;
    #1 async_reset_checks();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_mid_rst", in_ready, 1);
    repeat (4) @(posedge clk);
    #1 check("no_output_after_rst", out_valid, 0);

    push_vec(9);
    idle();
    drain();
    check("cnt_after_rst_restart", spec_cnt, 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
